// File: rtl/fpu_main_ctrl.sv
// fpu_main_ctrl: CPU-side command/handshake controller for the FPU core.
// Holds byte-written operands and opcode, turns a level start into a
// one-cycle core start pulse, waits for the core result with a timeout,
// and holds done until the CPU releases start.
//
// Handshake: the CPU raises start (level) while the controller is idle; the
// controller answers with exactly one core_start pulse, keeps busy high while
// waiting, accepts the first core_result_valid strobe seen in WAIT (including
// the core_start cycle), then raises done and holds it until start is low.
// Strobes outside WAIT carry no meaning and are dropped.
module fpu_main_ctrl #(
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] NAN_VALUE      = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [3:0]  cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  core_op,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic        core_start,
  input  logic        core_result_valid,
  input  logic [31:0] core_result,
  output logic [1:0]  dbg_state
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    OP_ILLEGAL = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT       = 2'd1,
    S_FINISH     = 2'd2,
    S_WAIT_START = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   snap_a_q, snap_a_d;
  logic [31:0]   snap_b_q, snap_b_d;
  logic [3:0]    snap_op_q, snap_op_d;
  logic [31:0]   result_q, result_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          core_start_q, core_start_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and datapath registers; everything returns to zero/IDLE on arst.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      snap_a_q     <= '0;
      snap_b_q     <= '0;
      snap_op_q    <= '0;
      result_q     <= '0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      snap_a_q     <= snap_a_d;
      snap_b_q     <= snap_b_d;
      snap_op_q    <= snap_op_d;
      result_q     <= result_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      core_start_q <= core_start_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic: CPU register writes (idle only) and the control FSM.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    snap_a_d     = snap_a_q;
    snap_b_d     = snap_b_q;
    snap_op_d    = snap_op_q;
    result_d     = result_q;
    timeout_d    = timeout_q;
    busy_d       = busy_q;
    done_d       = done_q;
    core_start_d = 1'b0;
    cnt_d        = cnt_q;

    // Operand/opcode writes are only honoured while no operation is running,
    // so the CPU can never disturb an operation in flight.
    if ((state_q == S_IDLE) && cpu_we) begin
      if (cpu_addr[3:2] == 2'b00) begin
        a_d[{cpu_addr[1:0], 3'b000} +: 8] = cpu_wdata;
      end else if (cpu_addr[3:2] == 2'b01) begin
        b_d[{cpu_addr[1:0], 3'b000} +: 8] = cpu_wdata;
      end else if (cpu_addr == 4'd8) begin
        op_d = cpu_wdata[3:0];
      end
    end

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (start) begin
          snap_a_d  = a_q;
          snap_b_d  = b_q;
          snap_op_d = op_q;
          if (op_q != OP_ILLEGAL) begin
            timeout_d    = 1'b0;
            cnt_d        = '0;
            core_start_d = 1'b1;
            busy_d       = 1'b1;
            state_d      = S_WAIT;
          end else begin
            result_d  = NAN_VALUE;
            timeout_d = 1'b1;
            state_d   = S_FINISH;
          end
        end
      end
      S_WAIT: begin
        // A result arriving on the last counted cycle still wins.
        if (core_result_valid) begin
          result_d = core_result;
          state_d  = S_FINISH;
        end else if (cnt_q == CNT_LAST) begin
          result_d  = NAN_VALUE;
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        // Start must be seen low before another operation can begin.
        if (!start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Combinational CPU readback mux.
  always_comb begin
    cpu_rdata = 8'h00;
    if (cpu_addr[3:2] == 2'b00) begin
      cpu_rdata = result_q[{cpu_addr[1:0], 3'b000} +: 8];
    end else if (cpu_addr[3:2] == 2'b01) begin
      cpu_rdata = b_q[{cpu_addr[1:0], 3'b000} +: 8];
    end else if (cpu_addr == 4'd8) begin
      cpu_rdata = {5'b00000, timeout_q, done_q, busy_q};
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign core_start = core_start_q;
  assign core_op    = snap_op_q;
  assign core_a     = snap_a_q;
  assign core_b     = snap_b_q;
  assign dbg_state  = state_q;

endmodule
